// File: rtl/ui_pkg.sv
// Shared encodings and default timing for the clock/stopwatch user interface.
package ui_pkg;

  typedef enum logic [1:0] {
    MODE_CLOCK  = 2'd0,
    MODE_SET    = 2'd1,
    MODE_SWATCH = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    FLD_SEC  = 2'd0,
    FLD_MIN  = 2'd1,
    FLD_HOUR = 2'd2,
    FLD_DAY  = 2'd3
  } fld_e;

  localparam logic [7:0] BLANK = 8'hFF;

  localparam int HOLD_DLY_DEF  = 500;
  localparam int RPT_PER_DEF   = 100;
  localparam int BLINK_PER_DEF = 500;
  localparam int SET_TMO_DEF   = 10000;

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_CLOCK: return MODE_SET;
      MODE_SET:   return MODE_SWATCH;
      default:    return MODE_CLOCK;
    endcase
  endfunction

endpackage

// File: rtl/key_edge.sv
// Key front end: 3-stage shift synchronizer with press-edge and held outputs.
module key_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  output logic press_o,
  output logic held_o
);

  logic [2:0] sync_q, sync_d;

  assign sync_d = {sync_q[1:0], key_i};

  // Keys are active-low, so idle is all ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= 3'b111;
    else         sync_q <= sync_d;
  end

  assign press_o = sync_q[2] & ~sync_q[1];
  assign held_o  = ~sync_q[1];

endmodule

// File: rtl/mode_ctrl.sv
// Mode state machine, set-mode edit commands with auto-repeat, blink and display mux.
module mode_ctrl
  import ui_pkg::*;
#(
  parameter int HOLD_DLY  = HOLD_DLY_DEF,
  parameter int RPT_PER   = RPT_PER_DEF,
  parameter int BLINK_PER = BLINK_PER_DEF,
  parameter int SET_TMO   = SET_TMO_DEF
) (
  input  logic       CLK1K,
  input  logic       RSTN,
  input  logic       KEY0,
  input  logic       KEY1,
  input  logic       KEY2,
  input  logic [7:0] CLK_SEC,
  input  logic [7:0] CLK_MIN,
  input  logic [7:0] CLK_HOUR,
  input  logic [7:0] CLK_DAY,
  input  logic [7:0] SW_SEC,
  input  logic [7:0] SW_MIN,
  input  logic [7:0] SW_HOUR,
  input  logic [7:0] SW_DAY,
  output logic [1:0] MODE,
  output logic [1:0] SET_SEL,
  output logic       INC,
  output logic [7:0] DISP_L,
  output logic [7:0] DISP_R,
  output logic       BLINK
);

  localparam int HW = $clog2(HOLD_DLY + 1);
  localparam int BW = $clog2(BLINK_PER);
  localparam int TW = $clog2(SET_TMO);

  localparam logic [HW-1:0] HOLD_END    = HW'(HOLD_DLY);
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_DLY - RPT_PER + 1);
  localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_PER - 1);
  localparam logic [BW-1:0] BLINK_HALF  = BW'(BLINK_PER / 2);
  localparam logic [TW-1:0] TMO_LAST    = TW'(SET_TMO - 1);

  logic [2:0] press, held;
  logic       unused_held;

  key_edge u_key0 (.clk_i(CLK1K), .rst_ni(RSTN), .key_i(KEY0), .press_o(press[0]), .held_o(held[0]));
  key_edge u_key1 (.clk_i(CLK1K), .rst_ni(RSTN), .key_i(KEY1), .press_o(press[1]), .held_o(held[1]));
  key_edge u_key2 (.clk_i(CLK1K), .rst_ni(RSTN), .key_i(KEY2), .press_o(press[2]), .held_o(held[2]));

  assign unused_held = &{1'b0, held[1:0]};

  mode_e         mode_q, mode_d;
  logic [1:0]    sel_q, sel_d;
  logic          page_q, page_d;
  logic          inc_q, inc_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [BW-1:0] blink_q, blink_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    disp_l_q, disp_l_d, disp_r_q, disp_r_d;

  logic       in_set, timeout, any_press, blink_on, page_eff, inc_accept;
  logic [7:0] src_day, src_hour, src_min, src_sec;

  assign in_set     = (mode_q == MODE_SET);
  assign any_press  = |press;
  assign timeout    = in_set && (tmo_q == TMO_LAST);
  assign blink_on   = (blink_q < BLINK_HALF);
  assign inc_accept = in_set && press[2] && !press[1] && !press[0] && !timeout;

  always_ff @(posedge CLK1K or negedge RSTN) begin
    if (!RSTN) begin
      mode_q   <= MODE_CLOCK;
      sel_q    <= FLD_SEC;
      page_q   <= 1'b0;
      inc_q    <= 1'b0;
      hold_q   <= '0;
      blink_q  <= '0;
      tmo_q    <= '0;
      disp_l_q <= 8'h00;
      disp_r_q <= 8'h00;
    end else begin
      mode_q   <= mode_d;
      sel_q    <= sel_d;
      page_q   <= page_d;
      inc_q    <= inc_d;
      hold_q   <= hold_d;
      blink_q  <= blink_d;
      tmo_q    <= tmo_d;
      disp_l_q <= disp_l_d;
      disp_r_q <= disp_r_d;
    end
  end

  // Timeout beats every key; among keys KEY0 > KEY1 > KEY2.
  always_comb begin : fsm_next
    mode_d = mode_q;
    sel_d  = sel_q;
    page_d = page_q;
    inc_d  = 1'b0;
    if (timeout) begin
      mode_d = MODE_CLOCK;
    end else if (press[0]) begin
      mode_d = next_mode(mode_q);
      if (mode_q == MODE_CLOCK) begin
        sel_d  = FLD_SEC;
        page_d = 1'b0;
      end
    end else if (press[1]) begin
      if (in_set) sel_d = sel_q + 2'd1;
      else        page_d = ~page_q;
    end else if (inc_accept) begin
      inc_d = 1'b1;
    end
    if (in_set && held[2] && !timeout && !press[0] && (hold_q == HOLD_END)) inc_d = 1'b1;
  end

  // hold_q counts cycles since the accepted KEY2 press; zero means no repeat armed.
  always_comb begin : counters_next
    hold_d = '0;
    if (in_set && held[2]) begin
      if (inc_accept)              hold_d = HW'(1);
      else if (hold_q == HOLD_END) hold_d = HOLD_RELOAD;
      else if (hold_q != '0)       hold_d = hold_q + 1'b1;
    end
    tmo_d = '0;
    if (in_set && !any_press) tmo_d = tmo_q + 1'b1;
    blink_d = (blink_q == BLINK_LAST) ? '0 : blink_q + 1'b1;
    if ((in_set && any_press) || (mode_q == MODE_CLOCK && press[0])) blink_d = '0;
  end

  always_comb begin : disp_next
    src_day  = CLK_DAY;
    src_hour = CLK_HOUR;
    src_min  = CLK_MIN;
    src_sec  = CLK_SEC;
    if (mode_q == MODE_SWATCH) begin
      src_day  = SW_DAY;
      src_hour = SW_HOUR;
      src_min  = SW_MIN;
      src_sec  = SW_SEC;
    end
    page_eff = in_set ? sel_q[1] : page_q;
    disp_l_d = page_eff ? src_day  : src_min;
    disp_r_d = page_eff ? src_hour : src_sec;
    // Odd fields (MIN, DAY) sit on the left byte of their page.
    if (in_set && !blink_on) begin
      if (sel_q[0]) disp_l_d = BLANK;
      else          disp_r_d = BLANK;
    end
  end

  assign MODE    = mode_q;
  assign SET_SEL = sel_q;
  assign INC     = inc_q;
  assign BLINK   = blink_on;
  assign DISP_L  = disp_l_q;
  assign DISP_R  = disp_r_q;

endmodule
